recon_block_raster_writer: RTL and testbench

//  Sits downstream of the block reconstruction stage. Accepts one

---
 rtl/recon_block_raster_writer.sv | 140 ++++++++++++++
 tb/tb_recon_block_raster_writer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/recon_block_raster_writer.sv
// Raster writer for reconstructed 8x8 blocks.
// A block is accepted whole from a 512-bit bus. It is then written one pixel
// per cycle into a frame memory in raster order. A synchronous read port lets
// a host read back the image.
`timescale 1ns/1ps
module recon_block_raster_writer #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12,
  localparam int COL_W = (IMG_W / 8 > 1) ? $clog2(IMG_W / 8) : 1,
  localparam int ROW_W = (IMG_H / 8 > 1) ? $clog2(IMG_H / 8) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [511:0]      blk_pixels,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic [COL_W-1:0]  blk_col,
  output logic [ROW_W-1:0]  blk_row,
  output logic              frame_done
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W / 8 - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H / 8 - 1);

  state_t             state_reg, state_next;
  logic [5:0]         pix_cnt_reg, pix_cnt_next;
  logic [COL_W-1:0]   blk_col_reg, blk_col_next;
  logic [ROW_W-1:0]   blk_row_reg, blk_row_next;
  logic [511:0]       hold_reg;
  logic               accept;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [7:0]         rd_data_reg;
  logic [7:0]         hold_pix [0:63];
  logic [7:0]         mem [0:IMG_W*IMG_H-1];

  // Split the held block into individually addressable pixels (k = r*8 + c)
  for (genvar gi = 0; gi < 64; gi++) begin : g_unpack
    assign hold_pix[gi] = hold_reg[8*gi +: 8];
  end

  // Frame address of the current pixel: row-of-blocks and in-block row/col
  assign wr_addr = ((ADDR_W'(blk_row_reg) << 3) + ADDR_W'(pix_cnt_reg[5:3])) * ADDR_W'(IMG_W)
                 + (ADDR_W'(blk_col_reg) << 3) + ADDR_W'(pix_cnt_reg[2:0]);

  assign blk_ready  = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign frame_done = (state_reg == DONE);
  assign blk_col    = blk_col_reg;
  assign blk_row    = blk_row_reg;
  assign rd_data    = rd_data_reg;

  // Control state, pixel counter and block position registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      pix_cnt_reg <= '0;
      blk_col_reg <= '0;
      blk_row_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pix_cnt_reg <= pix_cnt_next;
      blk_col_reg <= blk_col_next;
      blk_row_reg <= blk_row_next;
    end
  end

  // Next-state logic: accept in IDLE, stream 64 pixels, advance block position
  always_comb begin
    state_next   = state_reg;
    pix_cnt_next = pix_cnt_reg;
    blk_col_next = blk_col_reg;
    blk_row_next = blk_row_reg;
    accept       = 1'b0;
    wr_en        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (blk_valid) begin
          accept       = 1'b1;
          pix_cnt_next = '0;
          state_next   = WRITE;
        end
      end
      WRITE: begin
        wr_en        = 1'b1;
        pix_cnt_next = pix_cnt_reg + 6'd1;
        if (pix_cnt_reg == 6'd63) begin
          state_next = IDLE;
          if (blk_col_reg == LAST_COL) begin
            blk_col_next = '0;
            if (blk_row_reg == LAST_ROW) begin
              blk_row_next = '0;
              state_next   = DONE;
            end else begin
              blk_row_next = blk_row_reg + ROW_W'(1);
            end
          end else begin
            blk_col_next = blk_col_reg + COL_W'(1);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the whole block only at the accept edge
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_reg <= blk_pixels;
    end
  end

  // Frame memory write port; a reset edge never writes, so an abandoned block stops cleanly
  always_ff @(posedge clk) begin
    if (wr_en && reset) begin
      mem[wr_addr] <= hold_pix[pix_cnt_reg];
    end
  end

  // Registered read port; same-cycle read of a written address yields the old pixel
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_recon_block_raster_writer.sv
// Scoreboard bench for recon_block_raster_writer.
// Reads push their expected pixel into a queue, and a negedge monitor pops and
// compares when the data is due.
`timescale 1ns/1ps
module tb_recon_block_raster_writer;

  logic         clk;
  logic         reset;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_pixels;
  logic [11:0]  rd_addr;
  logic [7:0]   rd_data;
  logic         busy;
  logic [2:0]   blk_col;
  logic [2:0]   blk_row;
  logic         frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  typedef struct {
    logic [7:0]  exp;
    logic [11:0] addr;
    int          due;
  } rd_exp_t;
  rd_exp_t rd_q[$];

  recon_block_raster_writer #(.IMG_W(64), .IMG_H(64), .ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_pixels(blk_pixels), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .blk_col(blk_col), .blk_row(blk_row), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter, updated at every rising edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: count frame_done pulses and retire due read expectations
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      if (frame_done === 1'b1) done_cnt++;
      while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        e = rd_q.pop_front();
        if (e.due < cyc) begin
          checks++;
          errors++;
          $display("FAIL rd_stale addr %0d: expectation %0h not checked in time", e.addr, e.exp);
        end else begin
          checks++;
          if (rd_data !== e.exp) begin
            errors++;
            $display("FAIL rd_data addr %0d: got %0h expected %0h", e.addr, rd_data, e.exp);
          end
        end
      end
    end
  end

  // Called just after a rising edge: data is due after the next rising edge
  task automatic issue_read(input logic [11:0] addr, input logic [7:0] exp);
    rd_exp_t e;
    rd_addr = addr;
    e.exp  = exp;
    e.addr = addr;
    e.due  = cyc + 1;
    rd_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    blk_valid = 1'b0;
    repeat (3) step();
    reset = 1'b1;
  endtask

  // Present a block, wait (bounded) for blk_ready, return the accept cycle
  task automatic send_block(input logic [511:0] d, output int t);
    int n;
    n = 0;
    blk_pixels = d;
    blk_valid  = 1'b1;
    @(negedge clk);
    while (blk_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (blk_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: blk_ready stayed %b", blk_ready);
    end
    step();
    t = cyc;
    blk_valid = 1'b0;
  endtask

  function automatic logic [511:0] fill_blk(input logic [7:0] v);
    logic [511:0] d;
    for (int k = 0; k < 64; k++) d[8*k +: 8] = v;
    return d;
  endfunction

  function automatic logic [7:0] new_pix(input int b, input int k);
    return 8'((b * 5 + k + 64) % 256);
  endfunction

  function automatic logic [511:0] new_blk(input int b);
    logic [511:0] d;
    for (int k = 0; k < 64; k++) d[8*k +: 8] = new_pix(b, k);
    return d;
  endfunction

  initial begin
    logic [511:0] d;
    int t;
    int n;
    int done_before;
    reset      = 1'b0;
    blk_valid  = 1'b0;
    blk_pixels = '0;
    rd_addr    = '0;

    // 1. reset state
    repeat (2) step();
    @(negedge clk);
    check("reset_rd_data", 32'(rd_data), 32'h0);
    step();
    reset = 1'b1;
    @(negedge clk);
    check("rst_blk_ready", 32'(blk_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_blk_col", 32'(blk_col), 32'd0);
    check("rst_blk_row", 32'(blk_row), 32'd0);
    step();

    // 2. single block, pixel k = k
    for (int k = 0; k < 64; k++) d[8*k +: 8] = 8'(k);
    send_block(d, t);
    for (int j = 0; j <= 64; j++) begin
      @(negedge clk);
      check($sformatf("blk_ready_T+%0d", j + 1), 32'(blk_ready), (j == 64) ? 32'd1 : 32'd0);
      if (j != 64) step();
    end
    check("single_busy", 32'(busy), 32'd0);
    check("single_blk_col", 32'(blk_col), 32'd1);
    check("single_blk_row", 32'(blk_row), 32'd0);
    step();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        issue_read(12'(y * 64 + x), 8'(y * 8 + x));
        step();
      end

    // 3. full frame, block b filled with b
    do_reset();
    done_before = done_cnt;
    for (int b = 0; b < 64; b++) send_block(fill_blk(8'(b)), t);
    wait_until(t + 63);
    @(negedge clk);
    check("fd_before", 32'(frame_done), 32'd0);
    step();
    @(negedge clk);
    check("fd_pulse", 32'(frame_done), 32'd1);
    check("fd_ready", 32'(blk_ready), 32'd0);
    step();
    @(negedge clk);
    check("fd_after", 32'(frame_done), 32'd0);
    check("fd_ready_back", 32'(blk_ready), 32'd1);
    check("wrap_blk_col", 32'(blk_col), 32'd0);
    check("wrap_blk_row", 32'(blk_row), 32'd0);
    check("fd_count", 32'(done_cnt - done_before), 32'd1);
    step();
    issue_read(12'((8 * 3 + 5) * 64 + 8 * 2 + 1), 8'd26); step();
    issue_read(12'd0, 8'd0); step();
    issue_read(12'd4095, 8'd63); step();
    issue_read(12'(7 * 64 + 8), 8'd1); step();

    // 4. toggle blk_valid / garble blk_pixels during WRITE
    for (int k = 0; k < 64; k++) d[8*k +: 8] = 8'(k * 3 + 1);
    send_block(d, t);
    for (int i = 0; i < 61; i++) begin
      blk_valid  = i[0];
      blk_pixels = {16{$urandom}};
      step();
    end
    blk_valid = 1'b0;
    wait_until(t + 64);
    @(negedge clk);
    check("tog_ready", 32'(blk_ready), 32'd1);
    check("tog_blk_col", 32'(blk_col), 32'd1);
    repeat (3) step();
    @(negedge clk);
    check("tog_no_extra_busy", 32'(busy), 32'd0);
    check("tog_no_extra_col", 32'(blk_col), 32'd1);
    step();
    for (int k = 0; k < 64; k++) begin
      issue_read(12'((k / 8) * 64 + (k % 8)), 8'(k * 3 + 1));
      step();
    end

    // 5. reset during block 5, then a complete new frame
    do_reset();
    for (int b = 0; b < 6; b++) send_block(new_blk(b + 100), t);
    wait_until(t + 30);
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(blk_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_col", 32'(blk_col), 32'd0);
    check("midrst_row", 32'(blk_row), 32'd0);
    step();
    done_before = done_cnt;
    for (int b = 0; b < 64; b++) send_block(new_blk(b), t);
    wait_until(t + 66);
    check("frame2_fd_count", 32'(done_cnt - done_before), 32'd1);
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 64; x++) begin
        issue_read(12'(y * 64 + x), new_pix((y / 8) * 8 + x / 8, (y % 8) * 8 + x % 8));
        step();
      end

    // 6. read-during-write returns old data, then new data
    for (int k = 0; k < 64; k++) d[8*k +: 8] = 8'(255 - k);
    send_block(d, t);
    wait_until(t + 10);
    issue_read(12'd66, new_pix(0, 10));
    step();
    issue_read(12'd66, 8'(255 - 10));
    step();

    // drain outstanding reads (bounded)
    n = 0;
    while (rd_q.size() > 0 && n < 20) begin
      step();
      n++;
    end
    if (rd_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL rd_drain: %0d expectations left, required 0", rd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
